register_read_stage: RTL and testbench



---
 rtl/register_read_stage_pkg.sv | 19 +
 rtl/register_read_stage_operand_fwd.sv | 81 ++++++++
 rtl/register_read_stage.sv | 113 +++++++++++
 tb/tb_register_read_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_read_stage_pkg.sv
// Shared types for the register-read stage: FSM state encoding and the
// {select, data} operand bundle.
package register_read_stage_pkg;

    localparam int unsigned RR_DATA_W = 32;
    localparam int unsigned RR_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } StateRegRead;

    typedef struct packed {
        logic [RR_SEL_W-1:0]  sel;
        logic [RR_DATA_W-1:0] data;
    } operand_t;

endpackage

// File: rtl/register_read_stage_operand_fwd.sv
// One operand lane: accept-time forward latch, stall hold register,
// FRESH/HELD source mux, same-cycle writeback bypass and r0 masking.
module reg_operand_fwd
    import register_read_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  StateRegRead           state_i,
    input  logic                  accept_i,
    input  logic                  out_ready_i,
    input  logic [SEL_WIDTH-1:0]  in_sel_i,
    input  logic [SEL_WIDTH-1:0]  out_sel_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic                  wb_en_i,
    input  logic [SEL_WIDTH-1:0]  wb_sel_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    function automatic logic wb_hit(input logic                 en,
                                    input logic [SEL_WIDTH-1:0] wsel,
                                    input logic [SEL_WIDTH-1:0] sel);
        return en && (wsel == sel) && (sel != '0);
    endfunction

    logic                  fwd_q, fwd_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] base;

    // The register file returns the pre-write value when read and written
    // in the same cycle, so that write is captured here at accept time.
    always_comb begin
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        if (accept_i) begin
            fwd_d      = wb_hit(wb_en_i, wb_sel_i, in_sel_i);
            fwd_data_d = wb_data_i;
        end
    end

    always_comb begin
        base = '0;
        case (state_i)
            FRESH:   base = fwd_q ? fwd_data_q : rf_data_i;
            HELD:    base = hold_q;
            default: base = '0;
        endcase
        data_o = base;
        if (state_i == IDLE || out_sel_i == '0) begin
            data_o = '0;
        end else if (wb_hit(wb_en_i, wb_sel_i, out_sel_i)) begin
            data_o = wb_data_i;
        end
    end

    // While stalled the presented value already includes any bypassed write,
    // so capturing it keeps the hold register architecturally current.
    always_comb begin
        hold_d = hold_q;
        if (state_i != IDLE && !out_ready_i) begin
            hold_d = data_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: rtl/register_read_stage.sv
// Register-read pipeline stage between decode and execute: drives the
// register file read selects and presents resolved operands with valid/ready.
module register_read_stage
    import register_read_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SEL_WIDTH     = 4,
    parameter int unsigned PAYLOAD_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_WIDTH-1:0]     in_sel_ra,
    input  logic [SEL_WIDTH-1:0]     in_sel_rb,
    input  logic [SEL_WIDTH-1:0]     in_sel_rc,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic [SEL_WIDTH-1:0]     rf_read_sel_ra,
    output logic [SEL_WIDTH-1:0]     rf_read_sel_rb,
    output logic [SEL_WIDTH-1:0]     rf_read_sel_rc,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_ra,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_rb,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_rc,
    input  logic                     wb_write_en,
    input  logic [SEL_WIDTH-1:0]     wb_write_sel,
    input  logic [DATA_WIDTH-1:0]    wb_write_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data_ra,
    output logic [DATA_WIDTH-1:0]    out_data_rb,
    output logic [DATA_WIDTH-1:0]    out_data_rc,
    output logic [SEL_WIDTH-1:0]     out_sel_ra,
    output logic [SEL_WIDTH-1:0]     out_sel_rb,
    output logic [SEL_WIDTH-1:0]     out_sel_rc,
    output logic [PAYLOAD_WIDTH-1:0] out_payload
);

    StateRegRead              state_q, state_d;
    logic [SEL_WIDTH-1:0]     sel_ra_q, sel_ra_d;
    logic [SEL_WIDTH-1:0]     sel_rb_q, sel_rb_d;
    logic [SEL_WIDTH-1:0]     sel_rc_q, sel_rc_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
    logic                     accept;

    assign rf_read_sel_ra = in_sel_ra;
    assign rf_read_sel_rb = in_sel_rb;
    assign rf_read_sel_rc = in_sel_rc;

    always_comb begin
        in_ready  = (state_q == IDLE) || out_ready;
        out_valid = (state_q != IDLE);
        accept    = in_valid && in_ready;
        state_d   = state_q;
        sel_ra_d  = sel_ra_q;
        sel_rb_d  = sel_rb_q;
        sel_rc_d  = sel_rc_q;
        payload_d = payload_q;
        if (state_q == IDLE || out_ready) begin
            state_d = accept ? FRESH : IDLE;
        end else begin
            state_d = HELD;
        end
        if (accept) begin
            sel_ra_d  = in_sel_ra;
            sel_rb_d  = in_sel_rb;
            sel_rc_d  = in_sel_rc;
            payload_d = in_payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_ra_q  <= '0;
            sel_rb_q  <= '0;
            sel_rc_q  <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_ra_q  <= sel_ra_d;
            sel_rb_q  <= sel_rb_d;
            sel_rc_q  <= sel_rc_d;
            payload_q <= payload_d;
        end
    end

    assign out_sel_ra  = sel_ra_q;
    assign out_sel_rb  = sel_rb_q;
    assign out_sel_rc  = sel_rc_q;
    assign out_payload = payload_q;

    reg_operand_fwd #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_fwd_ra (
        .clk(clk), .rst_n(rst_n), .state_i(state_q), .accept_i(accept),
        .out_ready_i(out_ready), .in_sel_i(in_sel_ra), .out_sel_i(sel_ra_q),
        .rf_data_i(rf_read_data_ra), .wb_en_i(wb_write_en), .wb_sel_i(wb_write_sel),
        .wb_data_i(wb_write_data), .data_o(out_data_ra)
    );

    reg_operand_fwd #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_fwd_rb (
        .clk(clk), .rst_n(rst_n), .state_i(state_q), .accept_i(accept),
        .out_ready_i(out_ready), .in_sel_i(in_sel_rb), .out_sel_i(sel_rb_q),
        .rf_data_i(rf_read_data_rb), .wb_en_i(wb_write_en), .wb_sel_i(wb_write_sel),
        .wb_data_i(wb_write_data), .data_o(out_data_rb)
    );

    reg_operand_fwd #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_fwd_rc (
        .clk(clk), .rst_n(rst_n), .state_i(state_q), .accept_i(accept),
        .out_ready_i(out_ready), .in_sel_i(in_sel_rc), .out_sel_i(sel_rc_q),
        .rf_data_i(rf_read_data_rc), .wb_en_i(wb_write_en), .wb_sel_i(wb_write_sel),
        .wb_data_i(wb_write_data), .data_o(out_data_rc)
    );

endmodule

// File: tb/tb_register_read_stage.sv
// Bench for register_read_stage: a register file model behind the read ports,
// and a queue of accepted instructions whose operands are resolved against it.
module tb_register_read_stage;

    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int PW   = 32;
    localparam int BUSW = 3 * SW + 3 * DW + PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [SW-1:0] in_sel_ra, in_sel_rb, in_sel_rc;
    logic [PW-1:0] in_payload;
    logic [SW-1:0] rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc;
    logic [DW-1:0] rf_read_data_ra, rf_read_data_rb, rf_read_data_rc;
    logic          wb_write_en;
    logic [SW-1:0] wb_write_sel;
    logic [DW-1:0] wb_write_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data_ra, out_data_rb, out_data_rc;
    logic [SW-1:0] out_sel_ra, out_sel_rb, out_sel_rc;
    logic [PW-1:0] out_payload;

    always #5 clk = ~clk;

    register_read_stage #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .PAYLOAD_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel_ra(in_sel_ra), .in_sel_rb(in_sel_rb), .in_sel_rc(in_sel_rc),
        .in_payload(in_payload),
        .rf_read_sel_ra(rf_read_sel_ra), .rf_read_sel_rb(rf_read_sel_rb),
        .rf_read_sel_rc(rf_read_sel_rc),
        .rf_read_data_ra(rf_read_data_ra), .rf_read_data_rb(rf_read_data_rb),
        .rf_read_data_rc(rf_read_data_rc),
        .wb_write_en(wb_write_en), .wb_write_sel(wb_write_sel), .wb_write_data(wb_write_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_ra(out_data_ra), .out_data_rb(out_data_rb), .out_data_rc(out_data_rc),
        .out_sel_ra(out_sel_ra), .out_sel_rb(out_sel_rb), .out_sel_rc(out_sel_rc),
        .out_payload(out_payload)
    );

    // Register file: synchronous read returning the pre-write value, r0 not writable.
    logic [DW-1:0] mem [16] = '{default: '0};
    always @(posedge clk) begin
        rf_read_data_ra <= mem[rf_read_sel_ra];
        rf_read_data_rb <= mem[rf_read_sel_rb];
        rf_read_data_rc <= mem[rf_read_sel_rc];
        if (wb_write_en && wb_write_sel != '0) mem[wb_write_sel] <= wb_write_data;
    end

    typedef struct {
        logic [SW-1:0] sa, sb, sc;
        logic [PW-1:0] pay;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    wire [BUSW-1:0] out_bus = {out_sel_ra, out_sel_rb, out_sel_rc,
                               out_data_ra, out_data_rb, out_data_rc, out_payload};

    // Architectural value of a register as seen this cycle, including the write in flight.
    function automatic logic [DW-1:0] arch(input logic [SW-1:0] s);
        if (s == '0) return '0;
        if (wb_write_en && wb_write_sel == s) return wb_write_data;
        return mem[s];
    endfunction

    function automatic logic [BUSW-1:0] front_bus();
        if (sbq.size() == 0) return 'x;
        return {sbq[0].sa, sbq[0].sb, sbq[0].sc,
                arch(sbq[0].sa), arch(sbq[0].sb), arch(sbq[0].sc), sbq[0].pay};
    endfunction

    task automatic drive_in(input logic v, input logic [SW-1:0] a, input logic [SW-1:0] b,
                            input logic [SW-1:0] c, input logic [PW-1:0] p);
        in_valid = v; in_sel_ra = a; in_sel_rb = b; in_sel_rc = c; in_payload = p;
    endtask

    task automatic drive_wb(input logic en, input logic [SW-1:0] s, input logic [DW-1:0] d);
        wb_write_en = en; wb_write_sel = s; wb_write_data = d;
    endtask

    // Scoreboard bookkeeping for the coming edge; called after this cycle's checks.
    task automatic commit();
        exp_t e;
        if (out_valid && out_ready && sbq.size() != 0) void'(sbq.pop_front());
        if (in_valid && in_ready) begin
            e.sa = in_sel_ra; e.sb = in_sel_rb; e.sc = in_sel_rc; e.pay = in_payload;
            sbq.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive_in(1'b0, 4'd5, 4'd6, 4'd7, 32'h0);
        drive_wb(1'b0, 4'd0, 32'h0);
        out_ready = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_bus !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", out_bus); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if ({rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc} !== 12'h567) begin
            n_bad++; $display("FAIL reset_rf_sel: got %h want 567", {rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preload();
        logic [SW-1:0] s [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        logic [DW-1:0] v [7] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h1, 32'h6, 32'h70};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
            drive_wb(1'b1, s[i], v[i]);
        end
        @(negedge clk);
        drive_wb(1'b0, 4'd0, 32'h0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_in(1'b1, 4'd1, 4'd2, 4'd3, 32'hA0A0_0001);
        out_ready = 1'b1;
        #2;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin n_bad++; $display("FAIL b2b_first: got rdy/vld %b want 10", {in_ready, out_valid}); end
        commit();
        @(negedge clk);
        drive_in(1'b1, 4'd3, 4'd2, 4'd1, 32'hA0A0_0002);
        #2;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if ({out_data_ra, out_data_rb, out_data_rc} !== {32'h11, 32'h22, 32'h33}) begin
            n_bad++; $display("FAIL b2b_data1: got %h %h %h want 11 22 33", out_data_ra, out_data_rb, out_data_rc);
        end
        n_cmp++;
        if ({out_valid, out_bus} !== {1'b1, front_bus()}) begin n_bad++; $display("FAIL b2b_sb1: got %h want %h", out_bus, front_bus()); end
        commit();
        @(negedge clk);
        drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
        #2;
        n_cmp++;
        if ({out_data_ra, out_data_rb, out_data_rc} !== {32'h33, 32'h22, 32'h11}) begin
            n_bad++; $display("FAIL b2b_data2: got %h %h %h want 33 22 11", out_data_ra, out_data_rb, out_data_rc);
        end
        n_cmp++;
        if ({out_valid, out_bus} !== {1'b1, front_bus()}) begin n_bad++; $display("FAIL b2b_sb2: got %h want %h", out_bus, front_bus()); end
        commit();
        @(negedge clk);
        #2;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_write_issue();
        @(negedge clk);
        drive_in(1'b1, 4'd5, 4'd0, 4'd0, 32'hB0B0_0005);
        drive_wb(1'b1, 4'd5, 32'hAAAA);
        #2 commit();
        @(negedge clk);
        drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
        drive_wb(1'b0, 4'd0, 32'h0);
        #2;
        n_cmp++;
        if (out_data_ra !== 32'hAAAA) begin n_bad++; $display("FAIL wr_issue_ra: got %h want aaaa", out_data_ra); end
        n_cmp++;
        if ({out_valid, out_bus} !== {1'b1, front_bus()}) begin n_bad++; $display("FAIL wr_issue_sb: got %h want %h", out_bus, front_bus()); end
        commit();
    endtask

    task automatic test_write_present();
        @(negedge clk);
        drive_in(1'b1, 4'd0, 4'd6, 4'd0, 32'hC0C0_0006);
        #2 commit();
        @(negedge clk);
        drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
        drive_wb(1'b1, 4'd6, 32'hBEEF);
        #2;
        n_cmp++;
        if (out_data_rb !== 32'hBEEF) begin n_bad++; $display("FAIL wr_present_rb: got %h want beef", out_data_rb); end
        n_cmp++;
        if ({out_valid, out_bus} !== {1'b1, front_bus()}) begin n_bad++; $display("FAIL wr_present_sb: got %h want %h", out_bus, front_bus()); end
        commit();
        @(negedge clk);
        drive_wb(1'b0, 4'd0, 32'h0);
    endtask

    task automatic test_stall_update();
        logic [DW-1:0] want_rc;
        @(negedge clk);
        drive_in(1'b1, 4'd1, 4'd2, 4'd7, 32'hD0D0_0007);
        out_ready = 1'b1;
        #2 commit();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive_in(1'b1, 4'd4, 4'd4, 4'd4, 32'hDEAD_0004);
            out_ready = 1'b0;
            if (k == 2) drive_wb(1'b1, 4'd7, 32'h77);
            else        drive_wb(1'b0, 4'd0, 32'h0);
            want_rc = (k >= 2) ? 32'h77 : 32'h70;
            #2;
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready_%0d: got %b want 0", k, in_ready); end
            n_cmp++;
            if ({out_sel_rc, out_data_rc} !== {4'd7, want_rc}) begin
                n_bad++; $display("FAIL stall_rc_%0d: got %h/%h want 7/%h", k, out_sel_rc, out_data_rc, want_rc);
            end
            n_cmp++;
            if ({out_valid, out_bus} !== {1'b1, front_bus()}) begin n_bad++; $display("FAIL stall_sb_%0d: got %h want %h", k, out_bus, front_bus()); end
            commit();
        end
        @(negedge clk);
        drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
        drive_wb(1'b0, 4'd0, 32'h0);
        out_ready = 1'b1;
        #2;
        n_cmp++;
        if ({out_valid, out_bus} !== {1'b1, front_bus()}) begin n_bad++; $display("FAIL stall_release: got %h want %h", out_bus, front_bus()); end
        commit();
        @(negedge clk);
        #2;
        n_cmp++;
        if ({out_valid, sbq.size() == 0} !== 2'b01) begin
            n_bad++; $display("FAIL stall_single_xfer: got vld %b queue %0d want 0 0", out_valid, sbq.size());
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        drive_in(1'b1, 4'd0, 4'd0, 4'd3, 32'hE0E0_0000);
        drive_wb(1'b1, 4'd0, 32'hFFFF);
        #2 commit();
        @(negedge clk);
        drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
        #2;
        n_cmp++;
        if ({out_data_ra, out_data_rb} !== 64'h0) begin
            n_bad++; $display("FAIL r0_operands: got %h %h want 0 0", out_data_ra, out_data_rb);
        end
        n_cmp++;
        if ({out_valid, out_bus} !== {1'b1, front_bus()}) begin n_bad++; $display("FAIL r0_sb: got %h want %h", out_bus, front_bus()); end
        commit();
        @(negedge clk);
        drive_wb(1'b0, 4'd0, 32'h0);
    endtask

    task automatic test_reset_stall();
        @(negedge clk);
        drive_in(1'b1, 4'd1, 4'd2, 4'd3, 32'hF0F0_0001);
        out_ready = 1'b1;
        #2 commit();
        repeat (2) begin
            @(negedge clk);
            drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
            out_ready = 1'b0;
            #2 commit();
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_stall_pre: got out_valid %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_bus} !== '0) begin n_bad++; $display("FAIL rst_stall_outputs: got %b/%h want 0", out_valid, out_bus); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_stall_in_ready: got %b want 1", in_ready); end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL rst_stall_after: got vld/rdy %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            drive_in(1'($urandom % 2), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                     4'($urandom_range(0, 7)), $urandom);
            out_ready = ($urandom % 4) != 0;
            drive_wb(1'($urandom % 2), 4'($urandom_range(0, 7)), $urandom);
            #2;
            if (out_valid) begin
                n_cmp++;
                if (out_bus !== front_bus()) begin n_bad++; $display("FAIL rand_%0d: got %h want %h", i, out_bus, front_bus()); end
            end
            commit();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
            drive_wb(1'b0, 4'd0, 32'h0);
            out_ready = 1'b1;
            #2;
            if (out_valid) begin
                n_cmp++;
                if (out_bus !== front_bus()) begin n_bad++; $display("FAIL rand_drain_%0d: got %h want %h", i, out_bus, front_bus()); end
            end
            commit();
        end
        n_cmp++;
        if ({out_valid, sbq.size() == 0} !== 2'b01) begin
            n_bad++; $display("FAIL rand_empty: got vld %b queue %0d want 0 0", out_valid, sbq.size());
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_back_to_back();
        test_write_issue();
        test_write_present();
        test_stall_update();
        test_r0();
        test_reset_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
